uart_frame_sample_rx: RTL
=========================

// Module: uart_frame_sample_rx
// PURPOSE
//  Parametrised successor of the 8-bit streaming UART receiver. Parses framed UART byte stream
//  (SOF x4, 16-bit status, payload, XOR checksum, EOF) into complex samples of SAMPLE_W-bit
//  real + SAMPLE_W-bit imag. Writes one full-width sample per FIFO write into the FFT input
//  buffer. Adds header validation, checksum/EOF checking, overflow reporting.
// PARAMETERS
//  SAMPLE_W     16            bits per real/imag part; multiple of 8, range 8..32
//  SOF_WORD     32'hA55A_C33C SOF pattern, sent MSB byte first
//  EOF_BYTE     8'h0D         end-of-frame byte
//  TYPE_ACCEPT  5'd1          only accepted status type field
//  MAX_LEN      1024          max samples per frame; must be <= 2047
//  PART_LE      1             1: each part sent LS byte first; 0: MS byte first
// PORTS
//  clk          in   1            system clock
//  rst          in   1            synchronous active-high reset
//  uart_i       in   8            received byte
//  valid_i      in   1            uart_i valid, 1-cycle pulse per byte
//  fifo_full_i  in   1            downstream FIFO full
//  data_o       out  2*SAMPLE_W   {imag, real} sample
//  write_req_o  out  1            FIFO write strobe, 1 cycle
//  type_o       out  5            type field of current frame
//  frame_done_o out  1            1-cycle pulse: frame ended, checksum and EOF good
//  frame_err_o  out  1            1-cycle pulse: frame rejected/failed
//  err_code_o   out  2            0 bad header, 1 checksum, 2 EOF mismatch; valid with frame_err_o
//  overflow_o   out  1            1-cycle pulse: completed sample dropped, FIFO full
// BEHAVIOUR
//  - uart_i/valid_i/fifo_full_i registered once; FSM acts on registered copies. All outputs registered.
//  - Reset: all outputs 0, data_o 0, type_o 0. FSM -> SOF0. Byte/sample counters and checksum cleared.
//  - States: SOF0..SOF3, STAT0 (status[15:8]), STAT1 (status[7:0]), PAYLOAD, CHK, EOF.
//    Advance only on registered valid.
//  - SOFn: byte == SOF_WORD byte n -> next state. Mismatch -> SOF1 if byte == SOF byte 0,
//    else SOF0. No error pulse.
//  - STAT1: type = status[15:11], len = status[10:0]. Header is bad if type != TYPE_ACCEPT,
//    len == 0, or len > MAX_LEN.
//    Bad header: frame_err_o with code 0, then -> SOF0. Good header: type_o updated, -> PAYLOAD.
//  - Checksum = XOR of STAT0, STAT1 and all payload bytes. It resets on SOF3 -> STAT0.
//  - PAYLOAD: BPS = SAMPLE_W/4 bytes per sample. Real part first, then imag.
//    Byte order within each part is set by PART_LE.
//    On last byte of a sample:
//      if fifo_full_r == 0: write_req_o = 1 the next cycle, with data_o = sample.
//      else: overflow_o = 1 instead; sample discarded; frame continues.
//    Latency: valid_i of last byte -> write_req_o exactly 2 cycles later.
//    After sample len completes -> CHK.
//  - CHK: byte != checksum -> record checksum error. Always -> EOF.
//  - EOF: byte != EOF_BYTE -> frame_err_o, code 2. Else recorded checksum error -> frame_err_o, code 1.
//    Else frame_done_o. Then -> SOF0. If both fail, code 2 wins.
//  - Samples already written are never retracted on a later frame error.
//  - fifo_full_i is sampled only at sample completion. No stall: the UART cannot be back-pressured.
//  - Reset mid-frame: partial sample discarded; no write, done or err pulse in the reset cycle or after.
//  - write_req_o, frame_done_o, frame_err_o and overflow_o are never asserted for more than 1 cycle each.
//    At most one of frame_done_o/frame_err_o per frame.
//  - Counters: sample counter 11 bits; byte-in-sample counter $clog2(BPS) bits, wraps to 0 after each sample.
// STRUCTURE
//  - Shared include uart_rx_defs.vh: state localparams, ERR_HDR/ERR_CHK/ERR_EOF codes.
//  - Sub-module uart_sample_assembler: byte -> {imag,real} shift/insert register.
//    It has a byte counter and a sample_done pulse, and is parametrised by SAMPLE_W and PART_LE.
//  - Top: framing FSM, header check, checksum, output registers.
// TESTING
//  1. SOF A5 5A C3 3C, status 08 02 (type 1, len 2), payload 34 12 78 56 BC 9A F0 DE, good CHK, 0D
//     -> data_o 5678_1234 then DEF0_9ABC; frame_done_o 1 pulse; latency 2 cycles per last byte.
//  2. Status 10 02 (type 2) -> frame_err_o code 0, no write_req_o.
//     Status 08 00 (len 0) -> code 0. Next good frame is accepted.
//  3. Good frame with CHK byte corrupted (xor 01) -> both samples written, frame_err_o code 1, no frame_done_o.
//  4. Good frame with EOF byte 0A -> frame_err_o code 2. Also with bad CHK -> still code 2.
//  5. fifo_full_i high during second sample's last byte
//     -> 1 write, 1 overflow_o pulse, frame_done_o still asserted.
//  6. SOF A5 A5 5A C3 3C resync -> frame accepted.
//     rst asserted mid-payload -> all outputs 0, next frame parsed cleanly.
//     Also run SAMPLE_W=8 and 32 with PART_LE=0 and check byte ordering.

Source files
------------

// File: rtl/uart_frame_sample_rx_pkg.sv
// Shared definitions for the framed UART sample receiver: FSM states, error codes
// and the SOF byte lookup.
package uart_frame_sample_rx_pkg;

   typedef enum logic [3:0] {
      ST_SOF0,
      ST_SOF1,
      ST_SOF2,
      ST_SOF3,
      ST_STAT0,
      ST_STAT1,
      ST_PAYLOAD,
      ST_CHK,
      ST_EOF
   } state_t;

   localparam logic [1:0] ERR_HDR = 2'd0;
   localparam logic [1:0] ERR_CHK = 2'd1;
   localparam logic [1:0] ERR_EOF = 2'd2;

   // SOF word travels MSB byte first, so byte 0 is word[31:24].
   function automatic logic [7:0] sof_byte(input logic [31:0] word, input logic [1:0] idx);
      case (idx)
         2'd0:    return word[31:24];
         2'd1:    return word[23:16];
         2'd2:    return word[15:8];
         default: return word[7:0];
      endcase
   endfunction

endpackage

// File: rtl/uart_frame_sample_rx_assembler.sv
// Byte-to-sample assembler: inserts payload bytes into a {imag, real} word, real part
// first, with per-part byte order chosen by PART_LE.
module uart_frame_sample_rx_assembler #(
   parameter int SAMPLE_W = 16,
   parameter bit PART_LE  = 1'b1
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  clear,
   input  logic                  byte_valid,
   input  logic [7:0]            byte_data,
   output logic [2*SAMPLE_W-1:0] sample_next,
   output logic                  sample_done
);

   localparam int NB  = SAMPLE_W / 8;
   localparam int BPS = 2 * NB;
   localparam int CW  = $clog2(BPS);

   logic [CW-1:0]         cnt_q;
   logic [2*SAMPLE_W-1:0] sample_q;

   function automatic int slot(input int k);
      int j;
      j = k % NB;
      return (k / NB) * NB + (PART_LE ? j : NB - 1 - j);
   endfunction

   // sample_next already holds the current byte so the top can register it on completion.
   always_comb begin
      sample_next = sample_q;
      for (int k = 0; k < BPS; k++) begin
         if (cnt_q == CW'(k)) sample_next[slot(k)*8 +: 8] = byte_data;
      end
   end

   assign sample_done = byte_valid && (cnt_q == CW'(BPS - 1));

   always_ff @(posedge clk) begin
      if (rst || clear) begin
         cnt_q    <= '0;
         sample_q <= '0;
      end else if (byte_valid) begin
         sample_q <= sample_next;
         cnt_q    <= sample_done ? '0 : cnt_q + 1'b1;
      end
   end

endmodule

// File: rtl/uart_frame_sample_rx.sv
// Framed UART receiver: SOF hunt, header check, payload -> complex samples, XOR checksum
// and EOF validation, with registered FIFO write, done, error and overflow strobes.
//
// state      | meaning
// SOF0..SOF3 | matching SOF_WORD bytes 0..3
// STAT0      | status[15:8]
// STAT1      | status[7:0], header check
// PAYLOAD    | assembling samples
// CHK        | compare checksum byte
// EOF        | compare EOF byte, report frame result
module uart_frame_sample_rx
   import uart_frame_sample_rx_pkg::*;
#(
   parameter int          SAMPLE_W    = 16,
   parameter logic [31:0] SOF_WORD    = 32'hA55A_C33C,
   parameter logic [7:0]  EOF_BYTE    = 8'h0D,
   parameter logic [4:0]  TYPE_ACCEPT = 5'd1,
   parameter int          MAX_LEN     = 1024,
   parameter bit          PART_LE     = 1'b1
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [7:0]            uart_i,
   input  logic                  valid_i,
   input  logic                  fifo_full_i,
   output logic [2*SAMPLE_W-1:0] data_o,
   output logic                  write_req_o,
   output logic [4:0]            type_o,
   output logic                  frame_done_o,
   output logic                  frame_err_o,
   output logic [1:0]            err_code_o,
   output logic                  overflow_o
);

   logic [7:0]            byte_r;
   logic                  valid_r, full_r;
   state_t                state_q, next_state, sof_restart;
   logic [7:0]            stat_hi_q, chk_q;
   logic [10:0]           len_q, sample_cnt_q;
   logic                  chk_err_q;
   logic [4:0]            hdr_type;
   logic [10:0]           hdr_len;
   logic                  hdr_bad;
   logic                  asm_valid, sample_done;
   logic [2*SAMPLE_W-1:0] sample_next;
   logic                  hdr_ok, chk_clr, chk_acc, write_en, ovf_en, done_en, err_en;
   logic [1:0]            err_code;

   assign hdr_type    = stat_hi_q[7:3];
   assign hdr_len     = {stat_hi_q[2:0], byte_r};
   assign hdr_bad     = (hdr_type != TYPE_ACCEPT) || (hdr_len == 11'd0) || (hdr_len > 11'(MAX_LEN));
   assign asm_valid   = valid_r && (state_q == ST_PAYLOAD);
   // A mismatching byte may itself be the start of a new SOF.
   assign sof_restart = (byte_r == sof_byte(SOF_WORD, 2'd0)) ? ST_SOF1 : ST_SOF0;

   uart_frame_sample_rx_assembler #(
      .SAMPLE_W (SAMPLE_W),
      .PART_LE  (PART_LE)
   ) u_asm (
      .clk         (clk),
      .rst         (rst),
      .clear       (hdr_ok),
      .byte_valid  (asm_valid),
      .byte_data   (byte_r),
      .sample_next (sample_next),
      .sample_done (sample_done)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         byte_r  <= '0;
         valid_r <= 1'b0;
         full_r  <= 1'b0;
         state_q <= ST_SOF0;
      end else begin
         byte_r  <= uart_i;
         valid_r <= valid_i;
         full_r  <= fifo_full_i;
         state_q <= next_state;
      end
   end

   always_comb begin
      next_state = state_q;
      hdr_ok     = 1'b0;
      chk_clr    = 1'b0;
      chk_acc    = 1'b0;
      write_en   = 1'b0;
      ovf_en     = 1'b0;
      done_en    = 1'b0;
      err_en     = 1'b0;
      err_code   = ERR_HDR;
      if (valid_r) begin
         case (state_q)
            ST_SOF0: next_state = sof_restart;
            ST_SOF1: next_state = (byte_r == sof_byte(SOF_WORD, 2'd1)) ? ST_SOF2 : sof_restart;
            ST_SOF2: next_state = (byte_r == sof_byte(SOF_WORD, 2'd2)) ? ST_SOF3 : sof_restart;
            ST_SOF3: begin
               if (byte_r == sof_byte(SOF_WORD, 2'd3)) begin
                  next_state = ST_STAT0;
                  chk_clr    = 1'b1;
               end else begin
                  next_state = sof_restart;
               end
            end
            ST_STAT0: begin
               chk_acc    = 1'b1;
               next_state = ST_STAT1;
            end
            ST_STAT1: begin
               chk_acc = 1'b1;
               if (hdr_bad) begin
                  err_en     = 1'b1;
                  err_code   = ERR_HDR;
                  next_state = ST_SOF0;
               end else begin
                  hdr_ok     = 1'b1;
                  next_state = ST_PAYLOAD;
               end
            end
            ST_PAYLOAD: begin
               chk_acc = 1'b1;
               if (sample_done) begin
                  write_en = !full_r;
                  ovf_en   = full_r;
                  if (sample_cnt_q == len_q - 11'd1) next_state = ST_CHK;
               end
            end
            ST_CHK: next_state = ST_EOF;
            ST_EOF: begin
               next_state = ST_SOF0;
               if (byte_r != EOF_BYTE) begin
                  err_en   = 1'b1;
                  err_code = ERR_EOF;
               end else if (chk_err_q) begin
                  err_en   = 1'b1;
                  err_code = ERR_CHK;
               end else begin
                  done_en  = 1'b1;
               end
            end
            default: next_state = ST_SOF0;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         stat_hi_q    <= '0;
         len_q        <= '0;
         sample_cnt_q <= '0;
         chk_q        <= '0;
         chk_err_q    <= 1'b0;
      end else begin
         if (valid_r && state_q == ST_STAT0) stat_hi_q <= byte_r;
         if (hdr_ok) begin
            len_q        <= hdr_len;
            sample_cnt_q <= '0;
            chk_err_q    <= 1'b0;
         end else if (sample_done) begin
            sample_cnt_q <= sample_cnt_q + 11'd1;
         end
         if (chk_clr) chk_q <= '0;
         else if (chk_acc) chk_q <= chk_q ^ byte_r;
         if (valid_r && state_q == ST_CHK) chk_err_q <= (byte_r != chk_q);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         data_o       <= '0;
         write_req_o  <= 1'b0;
         type_o       <= '0;
         frame_done_o <= 1'b0;
         frame_err_o  <= 1'b0;
         err_code_o   <= '0;
         overflow_o   <= 1'b0;
      end else begin
         write_req_o  <= write_en;
         overflow_o   <= ovf_en;
         frame_done_o <= done_en;
         frame_err_o  <= err_en;
         err_code_o   <= err_en ? err_code : 2'd0;
         if (write_en) data_o <= sample_next;
         if (hdr_ok) type_o <= hdr_type;
      end
   end

endmodule
